// File: rtl/bus_arbiter_pkg.sv
// Shared types and encodings for the 4-master round-robin bus arbiter.
// Owner indices, FSM states and grant level constants live here.
package bus_arbiter_pkg;

   typedef logic [1:0] bus_owner_t;

   localparam bus_owner_t BUS_OWNER_M0 = 2'd0;
   localparam bus_owner_t BUS_OWNER_M1 = 2'd1;
   localparam bus_owner_t BUS_OWNER_M2 = 2'd2;
   localparam bus_owner_t BUS_OWNER_M3 = 2'd3;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   function automatic logic [3:0] owner_onehot(
      input bus_owner_t o
   );
      logic [3:0] v;
      v = {4{DISABLE}};
      unique case (o)
         BUS_OWNER_M0: v[0] = ENABLE;
         BUS_OWNER_M1: v[1] = ENABLE;
         BUS_OWNER_M2: v[2] = ENABLE;
         BUS_OWNER_M3: v[3] = ENABLE;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
// The arbiter takes the slave view; masters take the master view.
interface bus_arbiter_if;
   import bus_arbiter_pkg::*;

   logic       m0_req;
   logic       m1_req;
   logic       m2_req;
   logic       m3_req;
   logic       m0_grnt;
   logic       m1_grnt;
   logic       m2_grnt;
   logic       m3_grnt;
   bus_owner_t owner;
   logic       busy;

   modport slave (
      input  m0_req,
      input  m1_req,
      input  m2_req,
      input  m3_req,
      output m0_grnt,
      output m1_grnt,
      output m2_grnt,
      output m3_grnt,
      output owner,
      output busy
   );

   modport master (
      output m0_req,
      output m1_req,
      output m2_req,
      output m3_req,
      input  m0_grnt,
      input  m1_grnt,
      input  m2_grnt,
      input  m3_grnt,
      input  owner,
      input  busy
   );

endinterface

// File: rtl/bus_arbiter_rr_next_owner.sv
// Combinational round-robin search: scans start+1, +2, +3, start.
// With excl set the start index itself is never chosen.
module rr_next_owner
   import bus_arbiter_pkg::*;
(
   input  logic [3:0] req,
   input  bus_owner_t start,
   input  logic       excl,
   output logic       found,
   output bus_owner_t next
);

   bus_owner_t idx;

   // Walk from the farthest candidate back so the nearest one wins.
   always_comb begin
      found = 1'b0;
      next  = start;
      idx   = start;
      for (int k = 4; k >= 1; k--) begin
         idx = start + k[1:0];
         if (req[idx] && !(k == 4 && excl)) begin
            found = 1'b1;
            next  = idx;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the 4-master system bus with registered
// one-hot grants and an optional hold limit forcing rotation.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = 8
)
(
   input  logic        clk,
   input  logic        rst,
   bus_arbiter_if.slave bus
);

   localparam logic [HOLD_W-1:0] HOLD_MAX =
      HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST =
      HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

   arb_state_t        state_q, state_d;
   bus_owner_t        owner_q, owner_d;
   logic [HOLD_W-1:0] cnt_q, cnt_d;
   logic [3:0]        grnt_q, grnt_d;

   logic [3:0] req;
   logic       own_req;
   logic       excl;
   logic       found;
   bus_owner_t nxt;
   logic       hold_hit;

   assign req = {bus.m3_req, bus.m2_req,
                 bus.m1_req, bus.m0_req};

   assign own_req = req[owner_q];

   // While the owner still requests, search only the other masters.
   assign excl = (state_q == ARB_GRANT) && own_req;

   // >= keeps preemption armed once the counter has saturated.
   assign hold_hit = (MAX_HOLD != 0) && (cnt_q >= HOLD_LAST);

   rr_next_owner u_rr (
      .req   (req),
      .start (owner_q),
      .excl  (excl),
      .found (found),
      .next  (nxt)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      grnt_d  = {4{DISABLE}};
      unique case (state_q)
         ARB_IDLE: begin
            if (found) begin
               state_d = ARB_GRANT;
               owner_d = nxt;
               cnt_d   = '0;
            end
         end
         ARB_GRANT: begin
            if (own_req) begin
               if (hold_hit && found) begin
                  owner_d = nxt;
                  cnt_d   = '0;
               end else if (cnt_q < HOLD_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (found) begin
               owner_d = nxt;
               cnt_d   = '0;
            end else begin
               state_d = ARB_IDLE;
            end
         end
      endcase
      if (state_d == ARB_GRANT) begin
         grnt_d = owner_onehot(owner_d);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         owner_q <= BUS_OWNER_M3;
         cnt_q   <= '0;
         grnt_q  <= {4{DISABLE}};
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         grnt_q  <= grnt_d;
      end
   end

   assign bus.m0_grnt = grnt_q[0];
   assign bus.m1_grnt = grnt_q[1];
   assign bus.m2_grnt = grnt_q[2];
   assign bus.m3_grnt = grnt_q[3];
   assign bus.owner   = owner_q;
   assign bus.busy    = |grnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (hold limit 16 and 4) checked
// against a rule-level reference model, plus directed scenarios.
module tb_bus_arbiter;

   localparam int HA = 16;
   localparam int HB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   bus_arbiter_if ifa ();
   bus_arbiter_if ifb ();

   bus_arbiter #(.MAX_HOLD(HA), .HOLD_W(8)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   bus_arbiter #(.MAX_HOLD(HB), .HOLD_W(8)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   int n_cmp = 0;
   int n_err = 0;

   int own_a = 3, held_a = 0;
   int own_b = 3, held_b = 0;
   bit act_a = 0, act_b = 0;

   function automatic logic [3:0] gv_a();
      return {ifa.m3_grnt, ifa.m2_grnt, ifa.m1_grnt, ifa.m0_grnt};
   endfunction

   function automatic logic [3:0] gv_b();
      return {ifb.m3_grnt, ifb.m2_grnt, ifb.m1_grnt, ifb.m0_grnt};
   endfunction

   task automatic chk(input string tag,
                      input logic [7:0] obs,
                      input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: owner = index granted, act = bus granted,
   // held = number of consecutive cycles the owner has held the bus.
   function automatic void model(input logic [3:0] r,
                                 input int mh,
                                 inout int own,
                                 inout bit act,
                                 inout int held);
      int w;
      w = -1;
      if (act && r[own]) begin
         if (mh != 0 && held >= mh)
            for (int k = 3; k >= 1; k--)
               if (r[(own + k) % 4]) w = (own + k) % 4;
         if (w >= 0) begin
            own  = w;
            held = 1;
         end else begin
            held = held + 1;
         end
      end else begin
         for (int k = 4; k >= 1; k--)
            if (r[(own + k) % 4]) w = (own + k) % 4;
         if (w >= 0) begin
            own  = w;
            act  = 1;
            held = 1;
         end else begin
            act = 0;
         end
      end
   endfunction

   task automatic cycle(input logic [3:0] ra,
                        input logic [3:0] rb,
                        input logic rs);
      {ifa.m3_req, ifa.m2_req, ifa.m1_req, ifa.m0_req} = ra;
      {ifb.m3_req, ifb.m2_req, ifb.m1_req, ifb.m0_req} = rb;
      rst = rs;
      @(posedge clk);
      if (rs) begin
         own_a = 3; act_a = 0; held_a = 0;
         own_b = 3; act_b = 0; held_b = 0;
      end else begin
         model(ra, HA, own_a, act_a, held_a);
         model(rb, HB, own_b, act_b, held_b);
      end
      #1;
      chk("a_grnt", 8'(gv_a()), act_a ? 8'(1 << own_a) : 8'h0);
      chk("a_owner", 8'(ifa.owner), 8'(own_a));
      chk("a_busy", 8'(ifa.busy), 8'(act_a));
      chk("a_onehot", 8'($onehot0(gv_a())), 8'h1);
      chk("b_grnt", 8'(gv_b()), act_b ? 8'(1 << own_b) : 8'h0);
      chk("b_owner", 8'(ifb.owner), 8'(own_b));
      chk("b_busy", 8'(ifb.busy), 8'(act_b));
      chk("b_onehot", 8'($onehot0(gv_b())), 8'h1);
   endtask

   initial begin
      logic [3:0] r, ra, rb, ga, gb;
      int wa[4], wb[4], ma[4], mb[4];

      // Reset state
      cycle(4'h0, 4'h0, 1'b1);
      cycle(4'h0, 4'h0, 1'b1);
      chk("rst_grnt", 8'(gv_a()), 8'h0);
      chk("rst_owner", 8'(ifa.owner), 8'd3);
      chk("rst_busy", 8'(ifb.busy), 8'h0);

      // m2 requests alone, then reset mid-grant
      cycle(4'b0100, 4'b0100, 1'b0);
      chk("m2_grnt", 8'(gv_a()), 8'h04);
      chk("m2_owner", 8'(ifa.owner), 8'd2);
      chk("m2_busy", 8'(ifa.busy), 8'h1);
      repeat (4) cycle(4'b0100, 4'b0100, 1'b0);
      cycle(4'b0100, 4'b0100, 1'b1);
      chk("rst_mid_a", 8'(gv_a()), 8'h0);
      chk("rst_mid_b", 8'(gv_b()), 8'h0);

      // All request from idle, each master holds three cycles
      for (int c = 0; c <= 12; c++) begin
         for (int i = 0; i < 4; i++) r[i] = (c < 3 + 3 * i);
         cycle(r, r, 1'b0);
         chk("rr_order", 8'(gv_a()),
             (c < 12) ? 8'(1 << (c / 3)) : 8'h0);
      end

      // Owner 1 releases while m0 and m3 wait: m3 is next
      cycle(4'b0010, 4'b0010, 1'b0);
      cycle(4'b0010, 4'b0010, 1'b0);
      chk("own1", 8'(ifa.owner), 8'd1);
      cycle(4'b1001, 4'b1001, 1'b0);
      chk("rr_skip", 8'(gv_a()), 8'h08);

      // Hold limit 4: m0 held, m2 preempts in cycle 5
      cycle(4'h0, 4'h0, 1'b1);
      cycle(4'b0001, 4'b0001, 1'b0);
      chk("hold_c1", 8'(gv_b()), 8'h01);
      for (int k = 1; k <= 4; k++) begin
         cycle(4'b0101, 4'b0101, 1'b0);
         chk("hold_b", 8'(gv_b()), (k < 4) ? 8'h01 : 8'h04);
      end
      chk("hold_a", 8'(gv_a()), 8'h01);

      // Lone holder is never rotated away
      cycle(4'h0, 4'h0, 1'b1);
      for (int k = 0; k < 20; k++) begin
         cycle(4'b0001, 4'b0001, 1'b0);
         chk("lone_b", 8'(gv_b()), 8'h01);
      end

      // Random traffic
      cycle(4'h0, 4'h0, 1'b1);
      ra = '0;
      rb = '0;
      for (int i = 0; i < 4; i++) begin
         wa[i] = 0; wb[i] = 0; ma[i] = 0; mb[i] = 0;
      end
      for (int n = 0; n < 10000; n++) begin
         ga = gv_a();
         gb = gv_b();
         for (int i = 0; i < 4; i++) begin
            if (!ra[i]) ra[i] = ($urandom_range(2) == 0);
            else if (ga[i]) ra[i] = ($urandom_range(3) != 0);
            if (!rb[i]) rb[i] = ($urandom_range(2) == 0);
            else if (gb[i]) rb[i] = ($urandom_range(3) != 0);
         end
         cycle(ra, rb, 1'b0);
         ga = gv_a();
         gb = gv_b();
         for (int i = 0; i < 4; i++) begin
            wa[i] = (ra[i] && !ga[i]) ? wa[i] + 1 : 0;
            wb[i] = (rb[i] && !gb[i]) ? wb[i] + 1 : 0;
            if (wa[i] > ma[i]) ma[i] = wa[i];
            if (wb[i] > mb[i]) mb[i] = wb[i];
         end
      end
      for (int i = 0; i < 4; i++) begin
         chk("starve_a", 8'(ma[i] <= 3 * HA + 3), 8'h1);
         chk("starve_b", 8'(mb[i] <= 3 * HB + 3), 8'h1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
